// File: rtl/ram_banked_ctl.sv
// rtl/ram_banked_ctl.sv - banked DFFRAM controller with read pipeline and post-reset zero fill

// Behavioural stand-in for one 512x32 DFFRAM macro: byte-masked write, registered read
module dffram_512x32 #(
  parameter int COLS = 2
) (
`ifdef USE_POWER_PINS
  inout  wire         VPWR,
  inout  wire         VGND,
`endif
  input  logic        CLK,
  input  logic [3:0]  WE0,
  input  logic        EN0,
  input  logic [8:0]  A0,
  input  logic [31:0] Di0,
  output logic [31:0] Do0
);
  localparam int CB = (COLS > 1) ? $clog2(COLS) : 0;

  logic [31:0] r_mem [0:511];
  logic [8:0]  w_phys;

  // Column-interleaved placement: the low address bits pick the column block
  always_comb w_phys = 9'((A0 >> CB) | (A0 << (9 - CB)));

  // Byte-masked write; the read register only updates on read cycles
  always_ff @(posedge CLK) begin
    if (EN0) begin
      for (int b = 0; b < 4; b++) begin
        if (WE0[b]) r_mem[w_phys][8*b +: 8] <= Di0[8*b +: 8];
      end
      if (WE0 == 4'b0000) Do0 <= r_mem[w_phys];
    end
  end
endmodule

module ram_banked_ctl #(
  parameter  int DATA_BANKS     = 2,
  parameter  int DEPTH_BANKS    = 1,
  parameter  int COLS           = 2,
  parameter  int OUT_REG        = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int DW             = 32 * DATA_BANKS,
  localparam int AW             = 9 + $clog2(DEPTH_BANKS)
) (
`ifdef USE_POWER_PINS
  inout  wire                    VPWR,
  inout  wire                    VGND,
`endif
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ,
  input  logic [4*DATA_BANKS-1:0] WE,
  input  logic [AW-1:0]           A,
  input  logic [DW-1:0]           Di,
  output logic                    READY,
  output logic [DW-1:0]           Do,
  output logic                    DO_VALID
);
  localparam int RW = (DEPTH_BANKS > 1) ? $clog2(DEPTH_BANKS) : 1;

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  state_t                               r_state;
  logic [8:0]                           r_clr_addr;
  logic                                 r_ready;
  logic                                 r_rd_v;
  logic [RW-1:0]                        r_rd_row;
  logic                                 r_rd_oor;
  logic                                 w_clr;
  logic                                 w_acc;
  logic                                 w_wr;
  logic                                 w_rd;
  logic                                 w_oor;
  logic [RW-1:0]                        w_row;
  logic [DEPTH_BANKS-1:0][DW-1:0]       w_row_do;
  logic [DW-1:0]                        w_rd_data;

  if (DEPTH_BANKS > 1) begin : g_row_dec
    assign w_row = A[AW-1:9];
  end else begin : g_row_one
    assign w_row = '0;
  end

  // Rows past DEPTH_BANKS exist in the address space only for non power-of-two depths
  assign w_oor = (int'(w_row) >= DEPTH_BANKS);

  // Zero-fill runs from the first cycle out of reset; clr_addr 0 is written in S_RESET
  assign w_clr = !RST && (CLEAR_ON_RESET != 0) && (r_state != S_RUN);
  assign w_acc = REQ && r_ready && !RST;
  assign w_wr  = w_acc && (|WE);
  assign w_rd  = w_acc && !(|WE);
  assign READY = r_ready;

  // Reset / clear / run sequencing with READY as a registered output
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_RESET;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (CLEAR_ON_RESET != 0) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= 9'd1;
          end else begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 9'd1;
          if (r_clr_addr == 9'd511) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  for (genvar r = 0; r < DEPTH_BANKS; r++) begin : g_depth
    logic w_en;
    assign w_en = w_clr || ((w_wr || w_rd) && !w_oor && (int'(w_row) == r));

    for (genvar k = 0; k < DATA_BANKS; k++) begin : g_lane
      logic [3:0]  w_we;
      logic [8:0]  w_a;
      logic [31:0] w_di;
      assign w_we = w_clr ? 4'hF : (w_wr ? WE[4*k +: 4] : 4'h0);
      assign w_a  = w_clr ? r_clr_addr : A[8:0];
      assign w_di = w_clr ? 32'h0 : Di[32*k +: 32];

      dffram_512x32 #(.COLS(COLS)) u_ram (
`ifdef USE_POWER_PINS
        .VPWR (VPWR),
        .VGND (VGND),
`endif
        .CLK  (CLK),
        .WE0  (w_we),
        .EN0  (w_en),
        .A0   (w_a),
        .Di0  (w_di),
        .Do0  (w_row_do[r][32*k +: 32])
      );
    end
  end

  // Carry the row select alongside each read so the mux picks the right macro row
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_v   <= 1'b0;
      r_rd_row <= '0;
      r_rd_oor <= 1'b0;
    end else begin
      r_rd_v <= w_rd;
      if (w_rd) begin
        r_rd_row <= w_row;
        r_rd_oor <= w_oor;
      end
    end
  end

  // Row mux; out-of-range reads return zero
  always_comb begin
    w_rd_data = '0;
    for (int r = 0; r < DEPTH_BANKS; r++) begin
      if (!r_rd_oor && (int'(r_rd_row) == r)) w_rd_data = w_row_do[r];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] r_do;
    logic          r_do_valid;

    // Output register: Do holds the last read value between valid pulses
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_do       <= '0;
        r_do_valid <= 1'b0;
      end else begin
        r_do_valid <= r_rd_v;
        if (r_rd_v) r_do <= w_rd_data;
      end
    end

    assign Do       = r_do;
    assign DO_VALID = r_do_valid;
  end else begin : g_ocomb
    assign Do       = w_rd_data;
    assign DO_VALID = r_rd_v;
  end
endmodule

// File: tb/tb_ram_banked_ctl.sv
// tb/tb_ram_banked_ctl.sv - self-checking bench for ram_banked_ctl
module tb_ram_banked_ctl;
  logic        clk;
  logic        rst;
  logic        a_req, b_req;
  logic [7:0]  a_we, b_we;
  logic [9:0]  a_addr;
  logic [10:0] b_addr;
  logic [63:0] a_di, b_di, a_do, b_do;
  logic        a_ready, b_ready, a_valid, b_valid;

  int checks = 0;
  int failures = 0;

  // Two instances: A = 2 lanes x 2 rows, registered output; B = 2 lanes x 3 rows, unregistered
  ram_banked_ctl #(.DATA_BANKS(2), .DEPTH_BANKS(2), .COLS(2), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut_a (
    .CLK(clk), .RST(rst), .REQ(a_req), .WE(a_we), .A(a_addr), .Di(a_di),
    .READY(a_ready), .Do(a_do), .DO_VALID(a_valid)
  );

  ram_banked_ctl #(.DATA_BANKS(2), .DEPTH_BANKS(3), .COLS(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut_b (
    .CLK(clk), .RST(rst), .REQ(b_req), .WE(b_we), .A(b_addr), .Di(b_di),
    .READY(b_ready), .Do(b_do), .DO_VALID(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mem_a [0:1023];
  logic [63:0] mem_b [0:1535];
  int          cnt_a = 0, cnt_b = 0, cyc = 0;
  int          due_a[$], due_b[$];
  logic [63:0] dat_a[$], dat_b[$];
  logic [63:0] last_a = '0;

  initial begin : model_cmp
    logic        ev;
    logic [63:0] ed;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        cnt_a = 0; cnt_b = 0; last_a = '0;
        due_a.delete(); dat_a.delete(); due_b.delete(); dat_b.delete();
      end else begin
        if (a_req && cnt_a >= 512) begin
          if (a_we != 8'h00) begin
            for (int k = 0; k < 8; k++) if (a_we[k]) mem_a[a_addr][8*k +: 8] = a_di[8*k +: 8];
          end else begin
            due_a.push_back(cyc + 1);
            dat_a.push_back(mem_a[a_addr]);
          end
        end
        if (b_req && cnt_b >= 512) begin
          if (b_we != 8'h00) begin
            if (int'(b_addr) < 1536)
              for (int k = 0; k < 8; k++) if (b_we[k]) mem_b[b_addr][8*k +: 8] = b_di[8*k +: 8];
          end else begin
            due_b.push_back(cyc);
            dat_b.push_back((int'(b_addr) < 1536) ? mem_b[b_addr] : 64'h0);
          end
        end
        if (cnt_a < 512) begin
          cnt_a++;
          if (cnt_a == 512) for (int i = 0; i < 1024; i++) mem_a[i] = '0;
        end
        if (cnt_b < 512) begin
          cnt_b++;
          if (cnt_b == 512) for (int i = 0; i < 1536; i++) mem_b[i] = '0;
        end
      end
      @(negedge clk);
      ev = (due_a.size() > 0) && (due_a[0] == cyc);
      if (ev) begin
        void'(due_a.pop_front());
        last_a = dat_a.pop_front();
      end
      chk("a_ready", a_ready, (cnt_a >= 512));
      chk("a_valid", a_valid, ev);
      chk("a_do", a_do, last_a);
      ev = (due_b.size() > 0) && (due_b[0] == cyc);
      ed = '0;
      if (ev) begin
        void'(due_b.pop_front());
        ed = dat_b.pop_front();
      end
      chk("b_ready", b_ready, (cnt_b >= 512));
      chk("b_valid", b_valid, ev);
      if (ev) chk("b_do", b_do, ed);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic [7:0] w, input logic [9:0] ad, input logic [63:0] d);
    a_req = r; a_we = w; a_addr = ad; a_di = d;
  endtask

  task automatic drv_b(input logic r, input logic [7:0] w, input logic [10:0] ad, input logic [63:0] d);
    b_req = r; b_we = w; b_addr = ad; b_di = d;
  endtask

  task automatic wr_a(input logic [9:0] ad, input logic [7:0] w, input logic [63:0] d);
    drv_a(1'b1, w, ad, d); step(); drv_a(1'b0, 8'h00, '0, '0);
  endtask

  task automatic wr_b(input logic [10:0] ad, input logic [7:0] w, input logic [63:0] d);
    drv_b(1'b1, w, ad, d); step(); drv_b(1'b0, 8'h00, '0, '0);
  endtask

  task automatic rd_a(input logic [9:0] ad, input logic [63:0] exp, input string nm);
    drv_a(1'b1, 8'h00, ad, '0); step(); drv_a(1'b0, 8'h00, '0, '0); step();
    @(negedge clk);
    chk({nm, "_valid"}, a_valid, 1'b1);
    chk(nm, a_do, exp);
  endtask

  task automatic rd_b(input logic [10:0] ad, input logic [63:0] exp, input string nm);
    drv_b(1'b1, 8'h00, ad, '0); step(); drv_b(1'b0, 8'h00, '0, '0);
    @(negedge clk);
    chk({nm, "_valid"}, b_valid, 1'b1);
    chk(nm, b_do, exp);
  endtask

  task automatic wait_ready(output int low, output int vs);
    low = 0; vs = 0;
    while (low < 600) begin
      @(negedge clk);
      if (a_valid) vs++;
      if (a_ready) break;
      low++;
    end
  endtask

  logic [7:0]  t4_we [0:4] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
  logic [9:0]  t4_ad [0:4] = '{10'h020, 10'h020, 10'h021, 10'h021, 10'h021};
  logic [63:0] t4_di [0:4] = '{64'h1111, 64'h0, 64'h0, 64'h2222, 64'h0};
  logic [63:0] dsav  [0:8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int       low, vs, v2;
    logic [8:0] vpat;
    rst = 1'b1;
    drv_a(1'b0, 8'h00, '0, '0);
    drv_b(1'b0, 8'h00, '0, '0);

    // 1: reset, 512-cycle clear, reads of zero
    repeat (3) step();
    rst = 1'b0;
    wait_ready(low, vs);
    chk("t1_ready_low_cycles", low, 512);
    rd_a(10'h000, 64'h0, "t1_rd_000");
    rd_a(10'h1FF, 64'h0, "t1_rd_1ff");
    rd_a(10'h0AB, 64'h0, "t1_rd_0ab");

    // 2: two depth rows, no aliasing, Do holds
    wr_a(10'h005, 8'hFF, 64'hDEADBEEF_01234567);
    wr_a(10'h205, 8'hFF, 64'hA5A5A5A5_5A5A5A5A);
    rd_a(10'h005, 64'hDEADBEEF_01234567, "t2_rd_005");
    rd_a(10'h205, 64'hA5A5A5A5_5A5A5A5A, "t2_rd_205");
    repeat (3) step();
    @(negedge clk);
    chk("t2_do_hold", a_do, 64'hA5A5A5A5_5A5A5A5A);
    rd_a(10'h005, 64'hDEADBEEF_01234567, "t2_rd_005_again");

    // 3: byte enables
    wr_a(10'h010, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
    wr_a(10'h010, 8'b0000_0101, 64'h0);
    rd_a(10'h010, 64'hFFFFFFFF_FF00FF00, "t3_byte_merge");

    // 4: back-to-back mix
    step();
    vpat = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drv_a(1'b1, t4_we[i], t4_ad[i], t4_di[i]);
      else       drv_a(1'b0, 8'h00, '0, '0);
      @(negedge clk);
      vpat[i] = a_valid;
      dsav[i] = a_do;
      step();
    end
    drv_a(1'b0, 8'h00, '0, '0);
    chk("t4_valid_pattern", vpat, 9'h058);
    chk("t4_data_c3", dsav[3], 64'h1111);
    chk("t4_data_c4", dsav[4], 64'h0);
    chk("t4_data_c6", dsav[6], 64'h2222);

    // 5: out-of-range row on the 3-row instance
    wr_b(11'h000, 8'hFF, 64'h01234567_89ABCDEF);
    wr_b(11'h200, 8'hFF, 64'hFEDCBA98_76543210);
    wr_b(11'h400, 8'hFF, 64'h55555555_AAAAAAAA);
    wr_b(11'h600, 8'hFF, 64'hBADBADBA_DBADBADB);
    rd_b(11'h600, 64'h0, "t5_rd_oor");
    rd_b(11'h000, 64'h01234567_89ABCDEF, "t5_row0");
    rd_b(11'h200, 64'hFEDCBA98_76543210, "t5_row1");
    rd_b(11'h400, 64'h55555555_AAAAAAAA, "t5_row2");

    // 6: reset mid-clear, then mid-read
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (200) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    wait_ready(low, vs);
    chk("t6_ready_low_after_abort", low, 512);
    rd_a(10'h005, 64'h0, "t6_zero_005");
    rd_a(10'h205, 64'h0, "t6_zero_205");
    rd_a(10'h010, 64'h0, "t6_zero_010");
    rd_a(10'h020, 64'h0, "t6_zero_020");
    rd_b(11'h400, 64'h0, "t6_zero_b400");
    wr_a(10'h030, 8'hFF, 64'h30303030_30303030);
    drv_a(1'b1, 8'h00, 10'h030, '0);
    step();
    drv_a(1'b0, 8'h00, '0, '0);
    rst = 1'b1;
    vs = 0;
    @(negedge clk);
    if (a_valid) vs++;
    step();
    @(negedge clk);
    if (a_valid) vs++;
    step();
    rst = 1'b0;
    drv_a(1'b1, 8'h00, 10'h030, '0);
    wait_ready(low, v2);
    chk("t6_ready_low_after_read_abort", low, 512);
    chk("t6_no_valid_from_flushed_or_ignored", vs + v2, 0);
    rd_a(10'h030, 64'h0, "t6_zero_030");
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_banked_ctl.md
Name: ram_banked_ctl

Overview:
- Parametrised successor to the fixed two-bank 512x64 RAM wrapper.
- Tiles DFFRAM macros (512 words x 32 bits each) in two dimensions: DATA_BANKS side by side for width, DEPTH_BANKS stacked for depth.
- Adds a request/valid read pipeline, an optional output register, and a post-reset zero-fill state machine.
- Sits between a core's load/store unit or cache and the DFFRAM macros.

Parameters:
- DATA_BANKS, 2: number of 32-bit lanes; DW = 32*DATA_BANKS.
- DEPTH_BANKS, 1: number of 512-word rows; DEPTH = 512*DEPTH_BANKS; AW = 9 + clog2(DEPTH_BANKS), minimum 9.
- COLS, 2: passed unchanged to every DFFRAM instance.
- OUT_REG, 1: 1 adds an output register stage (read latency 2); 0 gives read latency 1.
- CLEAR_ON_RESET, 1: 1 zero-fills the whole array after reset; 0 makes the block ready immediately.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- VPWR, VGND  in  1 each  power pins, present only under USE_POWER_PINS, routed to every macro.
- REQ  in  1  access request; sampled only while READY=1.
- WE  in  4*DATA_BANKS  byte write enables; all zero means read.
- A  in  AW  word address; A[8:0] selects the in-bank word, A[AW-1:9] selects the depth row.
- Di  in  DW  write data.
- READY  out  1  block accepts requests.
- Do  out  DW  read data.
- DO_VALID  out  1  single-cycle pulse marking valid Do.

Behaviour:
- Reset, while RST=1: READY=0, DO_VALID=0, in-flight reads flushed, Do=0 when OUT_REG=1, all macro EN=0. With OUT_REG=0, Do is undefined until the first DO_VALID.
- State machine: RESET -> CLEAR (when CLEAR_ON_RESET=1) or RUN, entered on the first cycle with RST=0.
- CLEAR:
  - clr_addr runs 0..511, one word per cycle.
  - Writes all-zero data with all WE bits set to every bank in every depth row in parallel.
  - Takes exactly 512 cycles regardless of DEPTH_BANKS; READY=0 throughout.
  - Moves to RUN after clr_addr=511 and sets READY=1 on the next cycle.
- RUN: READY=1 permanently; REQ is ignored when READY=0 (no queuing).
- Write (REQ=1, WE!=0):
  - Only the depth row decoded from A[AW-1:9] gets EN=1.
  - WE[4k+3:4k] drives lane k; only the enabled bytes change.
  - Writes produce no DO_VALID and do not disturb Do.
- Read (REQ=1, WE=0):
  - The decoded row gets EN=1.
  - The row select is pipelined alongside the request, so the output mux picks the correct row.
  - DO_VALID asserts 1+OUT_REG cycles after the request cycle.
- Throughput is one access per cycle, with any mix of reads and writes back to back.
- Read-after-write to the same address in the next cycle returns the new data.
- With OUT_REG=1, Do holds the last read value until the next DO_VALID.
- Out-of-range address (row >= DEPTH_BANKS, only possible when DEPTH_BANKS is not a power of two):
  - Writes are dropped.
  - Reads return all-zero with a normal DO_VALID.
- RST asserted mid-CLEAR or mid-read: everything aborts, no DO_VALID from a pre-reset request, and CLEAR restarts from address 0.
- REQ=1 on the cycle RST falls is ignored, because READY is still 0.

Test Plan:
1. Defaults, CLEAR_ON_RESET=1: hold RST 3 cycles, release -> READY=0 for exactly 512 cycles, then 1; reading 0x000, 0x1FF and 0x0AB returns 64'h0 with DO_VALID 2 cycles after each REQ.
2. DATA_BANKS=2, DEPTH_BANKS=2, AW=10: write 64'hDEADBEEF_01234567 to A=0x005 and 64'hA5A5A5A5_5A5A5A5A to A=0x205 -> reads return each value unaliased and Do holds between reads.
3. Byte enables: write 64'hFFFF..FF to A=0x010, then write 64'h0 with WE=8'b0000_0101 -> read returns 64'hFFFFFFFF_FF00FF00.
4. Back-to-back W(A=0x20, 0x1111)/R(0x20)/R(0x21)/W(0x21, 0x2222)/R(0x21) -> DO_VALID pulses at cycles 3, 4 and 6 relative to the first request, with data 0x1111, 0x0 and 0x2222.
5. OUT_REG=0, DEPTH_BANKS=3: read A=0x600 (row 3, out of range) -> Do=0 and DO_VALID 1 cycle after REQ; a write to A=0x600 leaves rows 0-2 unchanged.
6. Assert RST at clear cycle 200, and again 1 cycle after a read REQ -> no DO_VALID after release, READY returns exactly 512 cycles after release, and memory reads all zero.
